// File: rtl/mux_arb_n_1.sv
// Registered N-to-1 multiplexer with fixed-priority or round-robin arbitration.
// The winning operand is held in an output register under a valid/ack handshake.
module mux_arb_n_1 #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int MODE     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enb,
  input  logic [0:CHANNELS-1]              req,
  input  logic [0:CHANNELS*WIDTH-1]        a,
  input  logic                             ack,
  output logic [0:CHANNELS-1]              grant,
  output logic [0:WIDTH-1]                 y,
  output logic                             vld,
  output logic [0:$clog2(CHANNELS)-1]      sel
);

  localparam int SW = $clog2(CHANNELS);

  logic [0:WIDTH-1]    y_q, y_d;
  logic [0:SW-1]       sel_q, sel_d;
  logic                vld_q, vld_d;
  logic [0:CHANNELS-1] grant_q, grant_d;
  logic [SW-1:0]       ptr_q, ptr_d;

  logic [SW-1:0]       start;
  logic [SW:0]         cand;
  logic [SW-1:0]       win;
  logic                win_found;
  logic                cap;

  // Search CHANNELS candidates starting at the pointer; the wrap is an explicit
  // subtract so non-power-of-two channel counts never alias onto a missing channel.
  always_comb begin
    start     = (MODE != 0) ? ptr_q : '0;
    cand      = '0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, start} + (SW+1)'(i);
      if (cand >= (SW+1)'(CHANNELS)) begin
        cand = cand - (SW+1)'(CHANNELS);
      end
      if (!win_found && req[cand[SW-1:0]]) begin
        win_found = 1'b1;
        win       = cand[SW-1:0];
      end
    end
  end

  assign cap = enb & (|req) & (~vld_q | ack);

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    grant_d = '0;
    ptr_d   = ptr_q;
    if (cap) begin
      y_d        = a[win*WIDTH +: WIDTH];
      sel_d      = win;
      vld_d      = 1'b1;
      grant_d[win] = 1'b1;
      if (MODE != 0) begin
        ptr_d = (win == SW'(CHANNELS-1)) ? '0 : win + 1'b1;
      end
    end else if (vld_q && ack) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q     <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y     = y_q;
  assign sel   = sel_q;
  assign vld   = vld_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_mux_arb_n_1.sv
// Directed bench for mux_arb_n_1: fixed-priority, round-robin (4 and 3 channels),
// backpressure, enable/drain and asynchronous reset behaviour.
module tb_mux_arb_n_1;

  logic        clk;
  logic        rst;
  logic        enb;
  logic        ack;
  logic [0:3]  req;
  logic [0:95] a;
  logic [0:2]  req3;
  logic [0:23] a3;

  logic [0:3]  f_grant, r_grant;
  logic [0:23] f_y, r_y;
  logic        f_vld, r_vld;
  logic [0:1]  f_sel, r_sel;

  logic [0:2]  c_grant;
  logic [0:7]  c_y;
  logic        c_vld;
  logic [0:1]  c_sel;

  int checks = 0;
  int errors = 0;

  mux_arb_n_1 #(.WIDTH(24), .CHANNELS(4), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .enb(enb), .req(req), .a(a), .ack(ack),
    .grant(f_grant), .y(f_y), .vld(f_vld), .sel(f_sel)
  );

  mux_arb_n_1 #(.WIDTH(24), .CHANNELS(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .enb(enb), .req(req), .a(a), .ack(ack),
    .grant(r_grant), .y(r_y), .vld(r_vld), .sel(r_sel)
  );

  mux_arb_n_1 #(.WIDTH(8), .CHANNELS(3), .MODE(1)) u_rr3 (
    .clk(clk), .rst(rst), .enb(enb), .req(req3), .a(a3), .ack(ack),
    .grant(c_grant), .y(c_y), .vld(c_vld), .sel(c_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [0:23] exp_y;
    rst = 1'b0; enb = 1'b1; ack = 1'b1; req = 4'b1111; req3 = 3'b000;
    a  = {$urandom, $urandom, $urandom};
    a3 = 24'h112233;
    exp_y = a[0:23];
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (r_y !== 24'h0 || r_vld !== 1'b0 || r_grant !== 4'b0000 || r_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold_rr got y=%h vld=%b grant=%b sel=%0d exp all zero", r_y, r_vld, r_grant, r_sel);
    end
    checks++;
    if (f_y !== 24'h0 || f_vld !== 1'b0 || f_grant !== 4'b0000 || f_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold_fix got y=%h vld=%b grant=%b sel=%0d exp all zero", f_y, f_vld, f_grant, f_sel);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (r_vld !== 1'b0 || r_grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_pre_edge got vld=%b grant=%b exp 0 0000", r_vld, r_grant);
    end
    @(posedge clk);
    #1;
    $display("reset: first edge sel=%0d grant=%b y=%h", r_sel, r_grant, r_y);
    checks++;
    if (r_sel !== 2'd0 || r_grant !== 4'b1000 || r_vld !== 1'b1 || r_y !== exp_y) begin
      errors++;
      $display("FAIL reset_first_cap_rr got sel=%0d grant=%b vld=%b y=%h exp 0 1000 1 %h", r_sel, r_grant, r_vld, r_y, exp_y);
    end
    checks++;
    if (f_sel !== 2'd0 || f_grant !== 4'b1000) begin
      errors++;
      $display("FAIL reset_first_cap_fix got sel=%0d grant=%b exp 0 1000", f_sel, f_grant);
    end
  endtask

  task automatic test_fixed_priority();
    a   = {24'h010101, 24'h020202, 24'h030303, 24'h040404};
    req = 4'b0110; ack = 1'b1; enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      $display("fixed: cycle %0d sel=%0d y=%h grant=%b", i, f_sel, f_y, f_grant);
      checks++;
      if (f_y !== 24'h020202 || f_sel !== 2'd1 || f_vld !== 1'b1) begin
        errors++;
        $display("FAIL fixed_word got y=%h sel=%0d vld=%b exp 020202 1 1", f_y, f_sel, f_vld);
      end
      checks++;
      if (f_grant !== 4'b0100) begin
        errors++;
        $display("FAIL fixed_grant got %b exp 0100", f_grant);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [0:3]  exp_g;
    logic [0:2]  exp_g3;
    logic [0:23] exp_y;
    do_reset();
    req = 4'b1111; req3 = 3'b111; ack = 1'b1; enb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_g  = 4'b1000 >> (i % 4);
      exp_g3 = 3'b100 >> (i % 3);
      exp_y  = 24'h010101 * ((i % 4) + 1);
      @(posedge clk);
      #1;
      $display("rr: cycle %0d sel=%0d grant=%b y=%h | rr3 sel=%0d grant=%b", i, r_sel, r_grant, r_y, c_sel, c_grant);
      checks++;
      if (r_sel !== 2'(i % 4) || r_grant !== exp_g || r_y !== exp_y || r_vld !== 1'b1) begin
        errors++;
        $display("FAIL rr4_cycle%0d got sel=%0d grant=%b y=%h exp %0d %b %h", i, r_sel, r_grant, r_y, i % 4, exp_g, exp_y);
      end
      checks++;
      if (c_sel !== 2'(i % 3) || c_grant !== exp_g3 || c_y !== 8'(8'h11 * ((i % 3) + 1))) begin
        errors++;
        $display("FAIL rr3_cycle%0d got sel=%0d grant=%b y=%h exp %0d %b", i, c_sel, c_grant, c_y, i % 3, exp_g3);
      end
    end
    req3 = 3'b000;
  endtask

  task automatic test_backpressure();
    req = 4'b0001; ack = 1'b1;
    @(posedge clk);
    #1;
    $display("bp: load sel=%0d y=%h", r_sel, r_y);
    checks++;
    if (r_y !== 24'h040404 || r_sel !== 2'd3 || r_grant !== 4'b0001) begin
      errors++;
      $display("FAIL bp_load got y=%h sel=%0d grant=%b exp 040404 3 0001", r_y, r_sel, r_grant);
    end
    req = 4'b1111; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      $display("bp: stall %0d vld=%b sel=%0d y=%h grant=%b", i, r_vld, r_sel, r_y, r_grant);
      checks++;
      if (r_y !== 24'h040404 || r_sel !== 2'd3 || r_vld !== 1'b1 || r_grant !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d got y=%h sel=%0d vld=%b grant=%b exp 040404 3 1 0000", i, r_y, r_sel, r_vld, r_grant);
      end
    end
    ack = 1'b1;
    @(posedge clk);
    #1;
    $display("bp: release sel=%0d y=%h vld=%b grant=%b", r_sel, r_y, r_vld, r_grant);
    checks++;
    if (r_y !== 24'h010101 || r_sel !== 2'd0 || r_vld !== 1'b1 || r_grant !== 4'b1000) begin
      errors++;
      $display("FAIL bp_passthrough got y=%h sel=%0d vld=%b grant=%b exp 010101 0 1 1000", r_y, r_sel, r_vld, r_grant);
    end
  endtask

  task automatic test_enable_drain();
    enb = 1'b0; ack = 1'b1; req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      $display("drain: cycle %0d vld=%b grant=%b y=%h", i, r_vld, r_grant, r_y);
      checks++;
      if (r_vld !== 1'b0 || r_grant !== 4'b0000 || r_y !== 24'h010101) begin
        errors++;
        $display("FAIL drain%0d got vld=%b grant=%b y=%h exp 0 0000 010101", i, r_vld, r_grant, r_y);
      end
    end
    enb = 1'b1; req = 4'b0001;
    @(posedge clk);
    #1;
    $display("drain: re-enable sel=%0d y=%h", r_sel, r_y);
    checks++;
    if (r_y !== 24'h040404 || r_sel !== 2'd3 || r_vld !== 1'b1 || r_grant !== 4'b0001) begin
      errors++;
      $display("FAIL reenable got y=%h sel=%0d vld=%b grant=%b exp 040404 3 1 0001", r_y, r_sel, r_vld, r_grant);
    end
  endtask

  task automatic test_mid_reset();
    req = 4'b0100; ack = 1'b1; enb = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (r_sel !== 2'd1 || r_grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_setup got sel=%0d grant=%b exp 1 0100", r_sel, r_grant);
    end
    #2;
    rst = 1'b0;
    #1;
    $display("midrst: async vld=%b y=%h grant=%b", r_vld, r_y, r_grant);
    checks++;
    if (r_vld !== 1'b0 || r_y !== 24'h0 || r_grant !== 4'b0000 || r_sel !== 2'd0) begin
      errors++;
      $display("FAIL midrst_async got vld=%b y=%h grant=%b sel=%0d exp 0 000000 0000 0", r_vld, r_y, r_grant, r_sel);
    end
    @(negedge clk);
    rst = 1'b1; req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      $display("midrst: restart %0d sel=%0d grant=%b", i, r_sel, r_grant);
      checks++;
      if (r_sel !== 2'(i) || r_grant !== (4'b1000 >> i)) begin
        errors++;
        $display("FAIL midrst_ptr%0d got sel=%0d grant=%b exp %0d", i, r_sel, r_grant, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_enable_drain();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_n_1.md
# mux_arb_n_1

Registered N-to-1 multiplexer with built-in arbitration and a valid/ack output handshake. It is the parametrised successor to the combinational 2:1 select path. Each of CHANNELS sources raises a request with its WIDTH-bit operand. The block picks one winner per cycle, using either fixed priority or round-robin. It acknowledges the winner with a one-cycle grant and holds the selected word in an output register until downstream consumes it. It sits between multiple datapath producers (register-file read ports, bypass sources, memory return) and a single shared consumer.

## Interface
- WIDTH, 24: data word width in bits.
- CHANNELS, 4: number of input channels, from 2 to 16.
- MODE, 1: arbitration mode. 0 = fixed priority (channel 0 highest). 1 = round-robin.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low. While low, all state is forced to reset values.
- enb  input  1  arbitration enable. When 0, no new grant is issued; the output register and handshake still operate.
- req  input  [0:CHANNELS-1]  per-channel request; req[k] belongs to channel k.
- a  input  [0:CHANNELS*WIDTH-1]  packed operands. Channel k occupies bits k*WIDTH through k*WIDTH+WIDTH-1.
- ack  input  1  downstream accepts y this cycle; only meaningful while vld=1.
- grant  output  [0:CHANNELS-1]  registered one-hot. grant[k]=1 for exactly one cycle when channel k's operand is captured.
- y  output  [0:WIDTH-1]  registered selected word.
- vld  output  1  y holds an unconsumed word.
- sel  output  [0:$clog2(CHANNELS)-1]  registered index of the channel whose word is in y.

## Operation
- Reset values: y=0, vld=0, grant=0, sel=0, round-robin pointer ptr=0.
- Output register states:
  - EMPTY (vld=0).
  - FULL (vld=1).
- Capture condition: cap = enb & (|req) & (~vld | ack).
- On cap:
  - the winner w is computed combinationally from req and ptr;
  - y <= a[w], sel <= w, vld <= 1, grant <= one-hot(w).
- When vld & ack & ~cap: vld <= 0. y and sel hold their last value.
- When vld & ~ack: y, sel, vld are held. No grant is issued, and requests stay pending.
- grant is 0 on every cycle without a capture.
- Arbitration with MODE=0: w is the lowest index k with req[k]=1.
- Arbitration with MODE=1:
  - w is the first k with req[k]=1, searching ptr, ptr+1, … CHANNELS-1, 0, … ptr-1.
  - On capture, ptr <= w+1, wrapping CHANNELS-1 -> 0.
  - ptr is unchanged without a capture.
- Requests are level-sensitive. A source keeps req high until it sees its grant bit, then deasserts (or keeps it high for another word). The block does not queue requests.
- Simultaneous ack and capture in FULL is a pass-through: old word consumed, new word loaded, vld stays 1, one word per cycle.
- enb=0 while FULL: ack still drains to EMPTY, and nothing new is loaded.
- Reset asserted mid-transfer: y, vld, grant, sel and ptr clear immediately (asynchronously), and the pending word is lost. Sources see no grant and must re-request.
- CHANNELS not a power of two: ptr wrap uses compare to CHANNELS-1, never a natural overflow.

## Timing
- Latency: req/a sampled at edge n; y, vld, grant and sel valid after edge n. One cycle req->vld.
- Throughput: one word per cycle with ack tied high and any req present.
- grant and y/vld rise on the same edge. A source sampling grant=1 at edge n+1 may change a/req for edge n+1.
- ack is sampled at the rising edge. There is no combinational path from ack, req, a or enb to any output.
- Reset release is synchronous to clk; the first capture can occur on the first edge after rst goes high.

## Test plan
- Reset: hold rst=0 with req=4'b1111 and random a, then release. Required: y=0, vld=0, grant=0, sel=0 until the first edge after release; then sel=0 and grant=4'b1000.
- Fixed priority (MODE=0): req=4'b0110, a={24'h010101,24'h020202,24'h030303,24'h040404}, ack=1. Required: y=24'h020202 and sel=1 every cycle while req is held; channel 2 never granted.
- Round-robin (MODE=1): req=4'b1111, ack=1 for 8 cycles. Required: sel sequence 0,1,2,3,0,1,2,3; grant one-hot each cycle.
- Backpressure: load channel 3 (y=24'h040404), hold ack=0 for 5 cycles with req=4'b1111. Required: y, sel and vld=1 held; grant=0. Then ack=1 for one cycle. Required: next word captured in the same edge; vld stays 1.
- Enable and drain: vld=1, set enb=0, pulse ack. Required: vld->0, grant stays 0 while enb=0. Re-enable with req=4'b0001: y=24'h040404, sel=3 one cycle later.
- Mid-operation reset: assert rst low asynchronously between edges while vld=1. Required: vld, y and grant go to 0 immediately, without waiting for a clock edge, and ptr restarts at 0.
